wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port ws_allowin  output  1  WB can accept a new bundle from MEM.
REQ-005 SHALL have port ms_to_ws_valid  input  1  MEM presents a valid bundle.
REQ-006 SHALL have port ms_to_ws_bus  input  `MS_TO_WS_BUS_WD (150)  MEM bundle, MSB to LSB: res_from_mem[1], mem_inst[12], rt_value[32], data_rdata[32], rdata_type[2], ex[1], gr_we[1], dest[5], final_result[32], pc[32].
REQ-007 SHALL have port rf_we  output  1  register-file write enable.
REQ-008 SHALL have port rf_waddr  output  5  register-file write address.
REQ-009 SHALL have port rf_wdata  output  32  register-file write data.
REQ-010 SHALL have port WB_dest  output  5  forwarding destination to ID; 0 when no write.
REQ-011 SHALL have port WB_result  output  32  forwarding data to ID (equals rf_wdata).
REQ-012 SHALL have ports debug_wb_pc  output  32, debug_wb_rf_wen  output  4, debug_wb_rf_wnum  output  5, debug_wb_rf_wdata  output  32  retirement trace.
REQ-013 SHALL have port retire_cnt  output  CNT_W  count of retired bundles.

Function
REQ-014 SHALL hold ws_valid and a registered bus copy ws_bus_r; ws_ready_go is constant 1; ws_allowin = !ws_valid || ws_ready_go (always 1).
REQ-015 SHALL, on each edge with ws_allowin=1, load ws_valid <= ms_to_ws_valid; SHALL load ws_bus_r <= ms_to_ws_bus only when ms_to_ws_valid=1, else hold ws_bus_r.
REQ-016 SHALL decode mem_inst: bit0 lw, bit2 lb, bit3 lbu, bit4 lh, bit5 lhu, bit6 lwl, bit7 lwr; other bits ignored; priority lb>lbu>lh>lhu>lwl>lwr>lw.
REQ-017 lb/lbu SHALL select byte rdata_type of data_rdata (0=[7:0] .. 3=[31:24]); lb sign-extends, lbu zero-extends.
REQ-018 lh/lhu SHALL select [15:0] for rdata_type 00, [31:16] for 10; lh sign-, lhu zero-extends; rdata_type 01/11 SHALL yield 0x00000000.
REQ-019 lwl SHALL yield type0 {rdata[7:0],rt[23:0]}, type1 {rdata[15:0],rt[15:0]}, type2 {rdata[23:0],rt[7:0]}, type3 rdata.
REQ-020 lwr SHALL yield type0 rdata, type1 {rt[31:24],rdata[31:8]}, type2 {rt[31:16],rdata[31:16]}, type3 {rt[31:8],rdata[31:24]}.
REQ-021 rf_wdata SHALL be the aligned load value when res_from_mem=1 (lw or no decoded bit: data_rdata), else final_result; purely combinational from ws_bus_r, zero added latency.
REQ-022 rf_we SHALL be ws_valid && gr_we && !ex; rf_waddr = dest.
REQ-023 WB_dest SHALL be dest & {5{rf_we}}; WB_result = rf_wdata.
REQ-024 debug_wb_pc = pc; debug_wb_rf_wen = {4{rf_we}}; debug_wb_rf_wnum = dest; debug_wb_rf_wdata = rf_wdata.
REQ-025 retire_cnt SHALL increment by 1 on each edge where ws_valid=1 and ex=0, wrapping modulo 2^CNT_W; bundles with ex=1 SHALL NOT count.
REQ-026 A bundle SHALL retire in exactly one cycle; back-to-back valid bundles SHALL retire on consecutive cycles with no bubble.

Reset
REQ-027 While reset=0 at an edge: ws_valid<=0, ws_bus_r<=0, retire_cnt<=0, overriding any concurrent ms_to_ws_valid.
REQ-028 During and after reset until a valid bundle loads: rf_we=0, WB_dest=0, debug_wb_rf_wen=0, debug_wb_pc=0, rf_wdata=0, ws_allowin=1.
REQ-029 Reset asserted mid-stream SHALL discard the held bundle with no RF write on the following cycle.

Verification
REQ-030 lb, rdata_type=01, data_rdata=0x123480FF, gr_we=1, dest=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xFFFFFF80, debug_wb_rf_wen=0xF.
REQ-031 lwl type1 and lwr type2, rdata=0xAABBCCDD, rt=0x11223344 -> rf_wdata 0xCCDD3344 then 0x1122AABB on consecutive cycles, retire_cnt +2.
REQ-032 lh, rdata_type=11 -> rf_wdata=0x00000000; lhu type10, rdata=0x8001FFFF -> 0x00008001.
REQ-033 ex=1, gr_we=1, dest=7 -> rf_we=0, WB_dest=0, retire_cnt unchanged; ALU bundle final_result=0xDEADBEEF -> rf_wdata=0xDEADBEEF.
REQ-034 CNT_W=4, 16 non-exception bundles from reset -> retire_cnt returns to 0; reset=0 while valid bundle held -> next cycle rf_we=0, retire_cnt=0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM bundle, aligns the load data, drives the
// register-file write port and retirement trace, and counts retired bundles.
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 150
`endif

module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        ws_allowin,
    input  logic                        ms_to_ws_valid,
    input  logic [`MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                        rf_we,
    output logic [4:0]                  rf_waddr,
    output logic [31:0]                 rf_wdata,
    output logic [4:0]                  WB_dest,
    output logic [31:0]                 WB_result,
    output logic [31:0]                 debug_wb_pc,
    output logic [3:0]                  debug_wb_rf_wen,
    output logic [4:0]                  debug_wb_rf_wnum,
    output logic [31:0]                 debug_wb_rf_wdata,
    output logic [CNT_W-1:0]            retire_cnt
);

    logic                        ws_valid;
    logic [`MS_TO_WS_BUS_WD-1:0] ws_bus_r;
    logic [CNT_W-1:0]            retire_cnt_reg;
    logic                        ws_ready_go;

    logic        res_from_mem;
    logic [11:0] mem_inst;
    logic [31:0] rt_value;
    logic [31:0] data_rdata;
    logic [1:0]  rdata_type;
    logic        ex;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;

    assign {res_from_mem, mem_inst, rt_value, data_rdata, rdata_type,
            ex, gr_we, dest, final_result, pc} = ws_bus_r;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ws_valid       <= 1'b0;
            ws_bus_r       <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (ws_allowin) begin
                ws_valid <= ms_to_ws_valid;
                if (ms_to_ws_valid) begin
                    ws_bus_r <= ms_to_ws_bus;
                end
            end
            // The held bundle retires on this edge unless it carries an exception.
            if (ws_valid && !ex) begin
                retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
            end
        end
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] lwl_val;
    logic [31:0] lwr_val;
    logic [31:0] mem_val;
    logic        unused_inst_bits;

    assign unused_inst_bits = ^{mem_inst[11:8], mem_inst[1]};

    always_comb begin
        sel_byte = data_rdata[7:0];
        lwl_val  = data_rdata;
        lwr_val  = data_rdata;
        case (rdata_type)
            2'd0: begin
                sel_byte = data_rdata[7:0];
                lwl_val  = {data_rdata[7:0], rt_value[23:0]};
                lwr_val  = data_rdata;
            end
            2'd1: begin
                sel_byte = data_rdata[15:8];
                lwl_val  = {data_rdata[15:0], rt_value[15:0]};
                lwr_val  = {rt_value[31:24], data_rdata[31:8]};
            end
            2'd2: begin
                sel_byte = data_rdata[23:16];
                lwl_val  = {data_rdata[23:0], rt_value[7:0]};
                lwr_val  = {rt_value[31:16], data_rdata[31:16]};
            end
            default: begin
                sel_byte = data_rdata[31:24];
                lwl_val  = data_rdata;
                lwr_val  = {rt_value[31:8], data_rdata[31:24]};
            end
        endcase
    end

    assign sel_half = rdata_type[1] ? data_rdata[31:16] : data_rdata[15:0];

    // Misaligned halfword types (01/11) produce zero rather than a partial value.
    always_comb begin
        mem_val = data_rdata;
        if (mem_inst[2]) begin
            mem_val = {{24{sel_byte[7]}}, sel_byte};
        end else if (mem_inst[3]) begin
            mem_val = {24'd0, sel_byte};
        end else if (mem_inst[4]) begin
            mem_val = rdata_type[0] ? 32'd0 : {{16{sel_half[15]}}, sel_half};
        end else if (mem_inst[5]) begin
            mem_val = rdata_type[0] ? 32'd0 : {16'd0, sel_half};
        end else if (mem_inst[6]) begin
            mem_val = lwl_val;
        end else if (mem_inst[7]) begin
            mem_val = lwr_val;
        end
    end

    assign rf_wdata          = res_from_mem ? mem_val : final_result;
    assign rf_we             = ws_valid && gr_we && !ex;
    assign rf_waddr          = dest;
    assign WB_dest           = dest & {5{rf_we}};
    assign WB_result         = rf_wdata;
    assign debug_wb_pc       = pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest;
    assign debug_wb_rf_wdata = rf_wdata;
    assign retire_cnt        = retire_cnt_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed load-alignment cases plus random
// bundles compared against a behavioural model of the stage.
module tb_wb_stage;

    logic         clk;
    logic         reset;
    logic         ms_to_ws_valid;
    logic [149:0] ms_to_ws_bus;
    logic         ws_allowin, ws_allowin4;
    logic         rf_we, rf_we4;
    logic [4:0]   rf_waddr, rf_waddr4;
    logic [31:0]  rf_wdata, rf_wdata4;
    logic [4:0]   wb_dest, wb_dest4;
    logic [31:0]  wb_result, wb_result4;
    logic [31:0]  dbg_pc, dbg_pc4;
    logic [3:0]   dbg_wen, dbg_wen4;
    logic [4:0]   dbg_wnum, dbg_wnum4;
    logic [31:0]  dbg_wdata, dbg_wdata4;
    logic [31:0]  retire_cnt;
    logic [3:0]   retire_cnt4;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    logic         m_valid;
    logic [149:0] m_bus;
    int unsigned  m_cnt;

    wb_stage dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .WB_dest(wb_dest), .WB_result(wb_result),
        .debug_wb_pc(dbg_pc), .debug_wb_rf_wen(dbg_wen),
        .debug_wb_rf_wnum(dbg_wnum), .debug_wb_rf_wdata(dbg_wdata),
        .retire_cnt(retire_cnt)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin4),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .WB_dest(wb_dest4), .WB_result(wb_result4),
        .debug_wb_pc(dbg_pc4), .debug_wb_rf_wen(dbg_wen4),
        .debug_wb_rf_wnum(dbg_wnum4), .debug_wb_rf_wdata(dbg_wdata4),
        .retire_cnt(retire_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [149:0] mk(input logic res, input logic [11:0] inst,
                                        input logic [31:0] rt, input logic [31:0] rd,
                                        input logic [1:0] typ, input logic ex,
                                        input logic we, input logic [4:0] dst,
                                        input logic [31:0] fr, input logic [31:0] pc);
        return {res, inst, rt, rd, typ, ex, we, dst, fr, pc};
    endfunction

    // Expected write data computed from the load rules with shifts and masks.
    function automatic logic [31:0] ref_wdata(input logic [149:0] b);
        logic [11:0] inst;
        logic [31:0] rt, rd, fr, v;
        logic [63:0] mask;
        int k;
        inst = b[148:137];
        rt   = b[136:105];
        rd   = b[104:73];
        k    = int'(b[72:71]);
        fr   = b[63:32];
        if (!b[149]) return fr;
        if (inst[2] || inst[3]) begin
            v = (rd >> (8 * k)) & 32'hFF;
            if (inst[2] && v[7]) v = v | 32'hFFFFFF00;
            return v;
        end
        if (inst[4] || inst[5]) begin
            if (k == 1 || k == 3) return 32'd0;
            v = (rd >> (8 * k)) & 32'hFFFF;
            if (inst[4] && v[15]) v = v | 32'hFFFF0000;
            return v;
        end
        if (inst[6]) begin
            mask = (64'd1 << (8 * (3 - k))) - 64'd1;
            return (rd << (8 * (3 - k))) | (rt & mask[31:0]);
        end
        if (inst[7]) return (rd >> (8 * k)) | (rt & ~(32'hFFFFFFFF >> (8 * k)));
        return rd;
    endfunction

    function automatic logic exp_we();
        return m_valid && m_bus[69] && !m_bus[70];
    endfunction

    // Drive one cycle's inputs, let the edge happen, advance the model, settle.
    task automatic tick(input logic rst_n, input logic v, input logic [149:0] b);
        reset          = rst_n;
        ms_to_ws_valid = v;
        ms_to_ws_bus   = b;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_bus   = '0;
            m_cnt   = 0;
        end else begin
            if (m_valid && !m_bus[70]) m_cnt = m_cnt + 1;
            m_valid = v;
            if (v) m_bus = b;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, mk(1'b0, 12'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1, 5'd3, 32'h5, 32'h100));
        tick(1'b0, 1'b1, mk(1'b0, 12'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1, 5'd3, 32'h5, 32'h100));
        tests++;
        if (rf_we !== 1'b0 || wb_dest !== 5'd0 || dbg_wen !== 4'd0) begin
            fails++;
            $display("FAIL reset_we: rf_we=%b WB_dest=%0d wen=%h required 0/0/0", rf_we, wb_dest, dbg_wen);
        end
        tests++;
        if (dbg_pc !== 32'd0 || rf_wdata !== 32'd0 || ws_allowin !== 1'b1 || retire_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: pc=%h wdata=%h allowin=%b cnt=%0d required 0/0/1/0",
                     dbg_pc, rf_wdata, ws_allowin, retire_cnt);
        end
        tick(1'b1, 1'b0, '0);
    endtask

    task automatic test_lb();
        tick(1'b1, 1'b1, mk(1'b1, 12'h004, 32'd0, 32'h123480FF, 2'd1, 1'b0, 1'b1, 5'd5, 32'd0, 32'h200));
        tests++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hFFFFFF80 || dbg_wen !== 4'hF) begin
            fails++;
            $display("FAIL lb_type1: we=%b waddr=%0d wdata=%h wen=%h required 1/5/ffffff80/f",
                     rf_we, rf_waddr, rf_wdata, dbg_wen);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned c0;
        tick(1'b1, 1'b0, '0);
        c0 = retire_cnt;
        tick(1'b1, 1'b1, mk(1'b1, 12'h040, 32'h11223344, 32'hAABBCCDD, 2'd1, 1'b0, 1'b1, 5'd8, 32'd0, 32'h300));
        tests++;
        if (rf_wdata !== 32'hCCDD3344 || rf_we !== 1'b1) begin
            fails++;
            $display("FAIL lwl_type1: wdata=%h we=%b required ccdd3344/1", rf_wdata, rf_we);
        end
        tick(1'b1, 1'b1, mk(1'b1, 12'h080, 32'h11223344, 32'hAABBCCDD, 2'd2, 1'b0, 1'b1, 5'd9, 32'd0, 32'h304));
        tests++;
        if (rf_wdata !== 32'h1122AABB || rf_we !== 1'b1 || dbg_pc !== 32'h304) begin
            fails++;
            $display("FAIL lwr_type2: wdata=%h we=%b pc=%h required 1122aabb/1/304", rf_wdata, rf_we, dbg_pc);
        end
        tick(1'b1, 1'b0, '0);
        tests++;
        if (retire_cnt !== c0 + 32'd2) begin
            fails++;
            $display("FAIL b2b_count: cnt=%0d required %0d", retire_cnt, c0 + 2);
        end
    endtask

    task automatic test_half();
        tick(1'b1, 1'b1, mk(1'b1, 12'h010, 32'd0, 32'hFFFFFFFF, 2'd3, 1'b0, 1'b1, 5'd4, 32'h1, 32'h400));
        tests++;
        if (rf_wdata !== 32'h00000000) begin
            fails++;
            $display("FAIL lh_type3: wdata=%h required 00000000", rf_wdata);
        end
        tick(1'b1, 1'b1, mk(1'b1, 12'h020, 32'd0, 32'h8001FFFF, 2'd2, 1'b0, 1'b1, 5'd4, 32'h1, 32'h404));
        tests++;
        if (rf_wdata !== 32'h00008001) begin
            fails++;
            $display("FAIL lhu_type2: wdata=%h required 00008001", rf_wdata);
        end
    endtask

    task automatic test_ex_alu();
        int unsigned c0;
        tick(1'b1, 1'b0, '0);
        c0 = retire_cnt;
        tick(1'b1, 1'b1, mk(1'b0, 12'd0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b1, 5'd7, 32'h1234, 32'h500));
        tests++;
        if (rf_we !== 1'b0 || wb_dest !== 5'd0) begin
            fails++;
            $display("FAIL ex_no_write: we=%b WB_dest=%0d required 0/0", rf_we, wb_dest);
        end
        tick(1'b1, 1'b1, mk(1'b0, 12'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 32'h504));
        tests++;
        if (retire_cnt !== c0 || rf_wdata !== 32'hDEADBEEF || wb_result !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL ex_alu: cnt=%0d wdata=%h result=%h required %0d/deadbeef/deadbeef",
                     retire_cnt, rf_wdata, wb_result, c0);
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b1, mk(1'b0, 12'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1, 5'd1, i, 32'h600 + i * 4));
        end
        tick(1'b1, 1'b0, '0);
        tests++;
        if (retire_cnt4 !== 4'd0 || retire_cnt !== 32'd16) begin
            fails++;
            $display("FAIL cnt_wrap: cnt4=%0d cnt=%0d required 0/16", retire_cnt4, retire_cnt);
        end
        tick(1'b1, 1'b1, mk(1'b0, 12'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1, 5'd2, 32'h77, 32'h700));
        tick(1'b0, 1'b0, '0);
        tests++;
        if (rf_we !== 1'b0 || retire_cnt !== 32'd0 || retire_cnt4 !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset: we=%b cnt=%0d cnt4=%0d required 0/0/0", rf_we, retire_cnt, retire_cnt4);
        end
    endtask

    task automatic test_random();
        logic [149:0] b;
        logic [11:0]  inst;
        logic         rst_n, v;
        logic [31:0]  ew;
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 29) != 0);
            v     = ($urandom_range(0, 3) != 0);
            inst  = ($urandom_range(0, 1) != 0) ? (12'd1 << $urandom_range(0, 11)) : 12'($urandom);
            b = mk(1'($urandom), inst, $urandom, $urandom, 2'($urandom), ($urandom_range(0, 4) == 0),
                   1'($urandom), 5'($urandom), $urandom, $urandom);
            tick(rst_n, v, b);
            ew = ref_wdata(m_bus);
            tests++;
            if (rf_we !== exp_we() || rf_waddr !== m_bus[68:64] || rf_wdata !== ew ||
                wb_dest !== (exp_we() ? m_bus[68:64] : 5'd0) || wb_result !== ew ||
                dbg_pc !== m_bus[31:0] || dbg_wen !== {4{exp_we()}} || dbg_wdata !== ew ||
                dbg_wnum !== m_bus[68:64] || ws_allowin !== 1'b1 ||
                retire_cnt !== m_cnt || retire_cnt4 !== m_cnt[3:0]) begin
                fails++;
                $display("FAIL random[%0d]: we=%b wdata=%h dest=%0d pc=%h cnt=%0d cnt4=%0d required %b/%h/%0d/%h/%0d/%0d",
                         i, rf_we, rf_wdata, wb_dest, dbg_pc, retire_cnt, retire_cnt4,
                         exp_we(), ew, exp_we() ? m_bus[68:64] : 5'd0, m_bus[31:0], m_cnt, m_cnt[3:0]);
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = '0;
        m_valid        = 1'b0;
        m_bus          = '0;
        m_cnt          = 0;
        @(negedge clk);
        test_reset();
        test_lb();
        test_back_to_back();
        test_half();
        test_ex_alu();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
